// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-operand and response signals of the ALU op sequencer.
// The slave modport is the sequencer side; master is the producer/ALU/consumer side.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_sel;
  logic       cmd_chain;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_result;
  logic       alu_carry;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic [1:0] rsp_sel;
  logic       busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_chain, alu_result, alu_carry, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_sel, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_chain, alu_result, alu_carry, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_sel, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands in a FIFO, drives them onto an external combinational ALU,
// waits SETTLE cycles, then captures and returns the result over a valid/ready handshake.
module alu_op_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input logic              clk,
  input logic              rst,
  alu_op_sequencer_if.slave bus
);

  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] Full       = (AW + 1)'(DEPTH);
  localparam logic [3:0]  SettleInit = 4'(SETTLE - 1);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic       chain;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e        state_q, state_d;
  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    alu_a_q, alu_a_d;
  logic [3:0]    alu_b_q, alu_b_d;
  logic [1:0]    alu_sel_q, alu_sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [3:0]    rsp_result_q, rsp_result_d;
  logic          rsp_carry_q, rsp_carry_d;
  logic [1:0]    rsp_sel_q, rsp_sel_d;
  logic [3:0]    last_q, last_d;

  logic push;
  logic pop;
  cmd_t head;
  cmd_t cmd_in;

  assign cmd_in = {bus.cmd_a, bus.cmd_b, bus.cmd_sel, bus.cmd_chain};
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_sel_d    = rsp_sel_q;
    last_d       = last_q;
    // Full is judged on the registered count, so a same-cycle pop never makes room.
    push         = bus.cmd_valid && (count_q != Full);
    pop          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          alu_a_d   = head.chain ? last_q : head.a;
          alu_b_d   = head.b;
          alu_sel_d = head.sel;
          cnt_d     = SettleInit;
          state_d   = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          rsp_result_d = bus.alu_result;
          rsp_carry_d  = bus.alu_carry;
          rsp_sel_d    = alu_sel_q;
          last_d       = bus.alu_result;
          rsp_valid_d  = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_sel_q    <= '0;
      last_q       <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_sel_q    <= rsp_sel_d;
      last_q       <= last_d;
    end
  end

  assign bus.cmd_ready  = (count_q != Full);
  assign bus.busy       = (state_q != StIdle) || (count_q != '0);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_sel    = rsp_sel_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: a SETTLE=1 instance checked every cycle against a transaction model,
// plus a SETTLE=3 instance checked with hand-computed expectations.
module tb_alu_op_sequencer;
  localparam int DEPTH   = 4;
  localparam int SETTLE0 = 1;
  localparam int SETTLE1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus0 ();
  alu_op_sequencer_if bus1 ();

  alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference 4-bit ALU: {carry, result}; carry is the borrow for SUB.
  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] sel);
    case (sel)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a | b};
      2'b10:   return {1'b0, a} + {1'b0, b};
      default: return {a < b, a - b};
    endcase
  endfunction

  function automatic logic [6:0] pk(input logic [3:0] r, input logic c, input logic [1:0] s);
    return {r, c, s};
  endfunction

  assign {bus0.alu_carry, bus0.alu_result} = alu_ref(bus0.alu_a, bus0.alu_b, bus0.alu_sel);
  assign {bus1.alu_carry, bus1.alu_result} = alu_ref(bus1.alu_a, bus1.alu_b, bus1.alu_sel);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model for instance 0
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic       chain;
  } cmd_t;

  cmd_t       mq[$];
  logic       inflight = 1'b0;
  logic       m_ok = 1'b0;
  int         cyc = 0;
  int         cap_at = 0;
  logic [3:0] m_a, m_b, m_res, m_last;
  logic [1:0] m_sel, m_rsel;
  logic       m_rv, m_carry;
  logic [4:0] m_alu;
  assign m_alu = alu_ref(m_a, m_b, m_sel);

  always @(posedge clk) begin : model_step
    automatic int pre     = mq.size();
    automatic bit do_pop  = !inflight && (pre > 0);
    automatic bit do_push = bus0.cmd_valid && (pre < DEPTH);
    cyc <= cyc + 1;
    if (rst) begin
      mq.delete();
      inflight <= 1'b0;
      m_rv     <= 1'b0;
      m_a      <= '0;
      m_b      <= '0;
      m_sel    <= '0;
      m_res    <= '0;
      m_carry  <= 1'b0;
      m_rsel   <= '0;
      m_last   <= '0;
      m_ok     <= 1'b1;
    end else begin
      if (m_rv && bus0.rsp_ready) begin
        m_rv     <= 1'b0;
        inflight <= 1'b0;
      end else if (inflight && !m_rv && cyc == cap_at) begin
        m_res   <= m_alu[3:0];
        m_carry <= m_alu[4];
        m_rsel  <= m_sel;
        m_last  <= m_alu[3:0];
        m_rv    <= 1'b1;
      end
      if (do_pop) begin
        m_a      <= mq[0].chain ? m_last : mq[0].a;
        m_b      <= mq[0].b;
        m_sel    <= mq[0].sel;
        inflight <= 1'b1;
        cap_at   <= cyc + SETTLE0;
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back({bus0.cmd_a, bus0.cmd_b, bus0.cmd_sel, bus0.cmd_chain});
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cmd_ready", bus0.cmd_ready, mq.size() < DEPTH);
      chk("busy", bus0.busy, inflight || (mq.size() != 0));
      chk("alu_a", bus0.alu_a, m_a);
      chk("alu_b", bus0.alu_b, m_b);
      chk("alu_sel", bus0.alu_sel, m_sel);
      chk("rsp_valid", bus0.rsp_valid, m_rv);
      chk("rsp_result", bus0.rsp_result, m_res);
      chk("rsp_carry", bus0.rsp_carry, m_carry);
      chk("rsp_sel", bus0.rsp_sel, m_rsel);
    end
  end

  logic [6:0] rlog[$];
  always @(posedge clk) begin
    if (!rst && bus0.rsp_valid && bus0.rsp_ready)
      rlog.push_back({bus0.rsp_result, bus0.rsp_carry, bus0.rsp_sel});
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                      input logic chain);
    bus0.cmd_valid = 1'b1;
    bus0.cmd_a     = a;
    bus0.cmd_b     = b;
    bus0.cmd_sel   = sel;
    bus0.cmd_chain = chain;
    for (int i = 0; i < 200; i++) begin
      if (bus0.cmd_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    bus0.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 200; i++) begin
      if (rlog.size() >= n) return;
      @(negedge clk);
    end
    chk("rsp_timeout", rlog.size(), n);
  endtask

  int saved;

  initial begin
    bus0.cmd_valid = 1'b0; bus0.cmd_a = '0; bus0.cmd_b = '0; bus0.cmd_sel = '0;
    bus0.cmd_chain = 1'b0; bus0.rsp_ready = 1'b1;
    bus1.cmd_valid = 1'b0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.cmd_sel = '0;
    bus1.cmd_chain = 1'b0; bus1.rsp_ready = 1'b1;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", bus0.cmd_ready, 1);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_rsp_valid", bus0.rsp_valid, 0);
    chk("rst_alu_a", bus0.alu_a, 0);

    // AND 0xC & 0xA, exact latency
    send(4'hC, 4'hA, 2'b00, 1'b0);
    idle();
    @(negedge clk);
    chk("and_alu_a", bus0.alu_a, 4'hC);
    chk("and_alu_b", bus0.alu_b, 4'hA);
    chk("and_early_valid", bus0.rsp_valid, 0);
    @(negedge clk);
    chk("and_valid", bus0.rsp_valid, 1);
    chk("and_result", bus0.rsp_result, 4'h8);
    wait_rsp(1);
    chk("and_log", rlog[0], pk(4'h8, 1'b0, 2'b00));

    // ADD then SUB, in order
    send(4'h9, 4'h8, 2'b10, 1'b0);
    send(4'h3, 4'h5, 2'b11, 1'b0);
    idle();
    wait_rsp(3);
    chk("add_log", rlog[1], pk(4'h1, 1'b1, 2'b10));
    chk("sub_log", rlog[2], pk(4'hE, 1'b1, 2'b11));

    // Chain uses last captured result
    send(4'h7, 4'h2, 2'b10, 1'b0);
    send(4'hF, 4'h4, 2'b01, 1'b1);
    idle();
    wait_rsp(5);
    chk("chain_first", rlog[3], pk(4'h9, 1'b0, 2'b10));
    chk("chain_second", rlog[4], pk(4'hD, 1'b0, 2'b01));
    chk("chain_alu_a", bus0.alu_a, 4'h9);

    // Backpressure: DEPTH+1 commands fill the FIFO plus the RESP slot
    bus0.rsp_ready = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) send(4'(k), 4'(k), 2'b10, 1'b0);
    idle();
    @(negedge clk);
    chk("bp_full", bus0.cmd_ready, 0);
    chk("bp_valid", bus0.rsp_valid, 1);
    chk("bp_result", bus0.rsp_result, 4'h2);
    repeat (3) @(negedge clk);
    chk("bp_hold", bus0.rsp_result, 4'h2);
    bus0.rsp_ready = 1'b1;
    wait_rsp(10);
    for (int i = 0; i < DEPTH + 1; i++) chk("bp_order", rlog[5 + i], pk(4'(2 * (i + 1)), 1'b0, 2'b10));

    // Reset during DRIVE with two commands still buffered
    bus0.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(4'hF, 4'(k + 1), 2'b00, 1'b0);
    idle();
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
    saved = rlog.size();
    chk("rst_saved", saved, 11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_valid", bus0.rsp_valid, 0);
    chk("midrst_alu_b", bus0.alu_b, 0);
    chk("midrst_ready", bus0.cmd_ready, 1);
    bus0.rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_rsp", rlog.size(), saved);
    send(4'hF, 4'h3, 2'b10, 1'b1);
    idle();
    @(negedge clk);
    chk("postrst_chain_a", bus0.alu_a, 4'h0);
    wait_rsp(saved + 1);
    chk("postrst_chain", rlog[saved], pk(4'h3, 1'b0, 2'b10));

    // SETTLE=3 instance: OR 0x5 | 0x2
    bus1.cmd_valid = 1'b1; bus1.cmd_a = 4'h5; bus1.cmd_b = 4'h2; bus1.cmd_sel = 2'b01;
    chk("s3_ready", bus1.cmd_ready, 1);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    chk("s3_valid0", bus1.rsp_valid, 0);
    for (int i = 1; i <= SETTLE1; i++) begin
      @(negedge clk);
      chk("s3_alu_a", bus1.alu_a, 4'h5);
      chk("s3_alu_b", bus1.alu_b, 4'h2);
      chk("s3_alu_sel", bus1.alu_sel, 2'b01);
      chk("s3_not_valid", bus1.rsp_valid, 0);
    end
    @(negedge clk);
    chk("s3_valid", bus1.rsp_valid, 1);
    chk("s3_result", bus1.rsp_result, 4'h7);
    chk("s3_carry", bus1.rsp_carry, 0);
    chk("s3_sel", bus1.rsp_sel, 2'b01);
    repeat (2) @(negedge clk);
    chk("s3_idle", bus1.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
